// File: rtl/mips_mem_pkg.sv
// Memory-side types shared by the store buffer and the load-extraction logic.
// Holds the access-size encoding, the buffered-store entry layout and the
// little-endian lane helpers that both directions must agree on.
package mips_mem_pkg;

    // Word-address width: byte-address bits [31:2].
    localparam int WORD_AW = 30;

    // Access size, identical to the encoding used by the load control.
    typedef enum logic [1:0] {
        SZ_WORD  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_BYTE  = 2'b10,
        SZ_BYTEU = 2'b11
    } st_size_e;

    // One buffered, already lane-aligned store.
    typedef struct packed {
        logic [WORD_AW-1:0] addr;
        logic [31:0]        data;
        logic [3:0]         be;
    } sb_entry_t;

    // True when an access of this size may start at byte offset off.
    function automatic logic size_aligned(input st_size_e sz, input logic [1:0] off);
        case (sz)
            SZ_WORD: return (off == 2'b00);
            SZ_HALF: return (off[0] == 1'b0);
            default: return 1'b1;
        endcase
    endfunction

    // Byte lanes touched by an access; bit i is byte lane i (little-endian).
    function automatic logic [3:0] lane_enables(input st_size_e sz, input logic [1:0] off);
        case (sz)
            SZ_WORD: return 4'b1111;
            SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b0001 << off;
        endcase
    endfunction

endpackage

// File: rtl/store_align.sv
// Store alignment: turns a sized MEM-stage store into a word address,
// lane-replicated write data, byte enables and a misalignment flag.
// Purely combinational.
module store_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]         st_size,
    input  logic [31:0]        st_addr,
    input  logic [31:0]        st_data,
    output logic [WORD_AW-1:0] word_addr,
    output logic [31:0]        wdata,
    output logic [3:0]         be,
    output logic               misaligned
);

    st_size_e   size;
    logic [1:0] off;

    assign size      = st_size_e'(st_size);
    assign off       = st_addr[1:0];
    assign word_addr = st_addr[31:2];

    // Replicate the narrow value into every lane so memory only needs the byte enables.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first; a path
        // that leaves one unassigned would infer a latch.
        wdata      = st_data;
        be         = lane_enables(size, off);
        misaligned = !size_aligned(size, off);
        case (size)
            SZ_WORD: wdata = st_data;
            SZ_HALF: wdata = {2{st_data[15:0]}};
            default: wdata = {4{st_data[7:0]}};
        endcase
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: accepts SW/SH/SB from the MEM stage, aligns them, queues them
// in an in-order FIFO and drains the head to data memory over req/ack.
// Also reports loads that hit a pending store word so the hazard unit can stall.
module store_buffer
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = WORD_AW
) (
    input  logic          clk,
    input  logic          reset_n,
    // store request from MEM
    input  logic          st_valid,
    output logic          st_ready,
    input  logic [1:0]    st_size,
    input  logic [31:0]   st_addr,
    input  logic [31:0]   st_data,
    output logic          misalign,
    // load hazard probe
    input  logic          ld_check,
    input  logic [31:0]   ld_addr,
    output logic          ld_conflict,
    // drain port to data memory
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    input  logic          mem_ack,
    output logic          empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // ------------------------------------------------------------------
    // Alignment of the incoming store
    // ------------------------------------------------------------------
    logic [WORD_AW-1:0] al_addr;
    logic [31:0]        al_data;
    logic [3:0]         al_be;
    logic               al_misaligned;

    store_align u_align (
        .st_size    (st_size),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .word_addr  (al_addr),
        .wdata      (al_data),
        .be         (al_be),
        .misaligned (al_misaligned)
    );

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    sb_entry_t        entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             misalign_q;

    logic full;
    logic accept;
    logic push;
    logic pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    // Derived from registered count only, so ready never waits on mem_ack.
    assign st_ready = !full;
    assign accept   = st_valid && st_ready;
    // A misaligned store still completes the handshake but is never queued.
    assign push     = accept && !al_misaligned;
    assign mem_req  = !empty;
    assign pop      = mem_req && mem_ack;
    assign misalign = misalign_q;

    // Pointer, occupancy and misalign-pulse bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            misalign_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples the pre-edge values regardless of statement order.
            misalign_q <= accept && al_misaligned;
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage: written at the tail on push.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the entry array is cleared on reset so a stale word address can
            // never show up on the drain port or match a load after reset.
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (push) begin
            entries[tail] <= '{addr: al_addr, data: al_data, be: al_be};
        end
    end

    // Drain port: head entry while requesting, all zeros when idle.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (mem_req) begin
            mem_addr  = AW'(entries[head].addr);
            mem_wdata = entries[head].data;
            mem_be    = entries[head].be;
        end
    end

    // Word-granular compare of the load against every occupied entry; the
    // entry being pushed this cycle is not yet occupied and so never matches.
    always_comb begin
        logic [PTR_W-1:0] rel;
        logic             hit;
        rel = '0;
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rel = PTR_W'(i) - head;
            if ((CNT_W'(rel) < count) && (entries[i].addr == ld_addr[31:2])) begin
                hit = 1'b1;
            end
        end
        ld_conflict = ld_check && hit;
    end

    // The byte offset of a load is irrelevant to a word-granular hazard.
    logic unused_ld_off;
    assign unused_ld_off = ^ld_addr[1:0];

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed steps followed by a randomized phase, all
// compared every cycle against a queue-based reference of pending stores.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        st_valid;
    logic        st_ready;
    logic [1:0]  st_size;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        misalign;
    logic        ld_check;
    logic [31:0] ld_addr;
    logic        ld_conflict;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        empty;

    store_buffer #(.DEPTH(DEPTH), .AW(30)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .st_valid    (st_valid),
        .st_ready    (st_ready),
        .st_size     (st_size),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .misalign    (misalign),
        .ld_check    (ld_check),
        .ld_addr     (ld_addr),
        .ld_conflict (ld_conflict),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_be      (mem_be),
        .mem_ack     (mem_ack),
        .empty       (empty)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } ref_t;

    ref_t        model_q[$];
    bit          exp_mis = 1'b0;
    logic [29:0] pop_log[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Legality from the size rules: words on 4-byte, halves on 2-byte boundaries.
    function automatic bit ref_legal(input logic [1:0] sz, input logic [31:0] a);
        int off;
        off = int'(a % 4);
        if (sz == 2'd0) return off == 0;
        if (sz == 2'd1) return (off % 2) == 0;
        return 1'b1;
    endfunction

    // Expected entry computed arithmetically: lane mask shifted by offset,
    // data replicated by multiplication.
    function automatic ref_t ref_entry(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        ref_t e;
        int   off;
        off    = int'(a % 4);
        e.addr = 30'(a / 4);
        if (sz == 2'd0) begin
            e.be   = 4'd15;
            e.data = d;
        end else if (sz == 2'd1) begin
            e.be   = 4'(3 << off);
            e.data = (d % 32'h10000) * 32'h00010001;
        end else begin
            e.be   = 4'(1 << off);
            e.data = (d % 32'h100) * 32'h01010101;
        end
        return e;
    endfunction

    // One clock: compare every output at the falling edge, then advance the
    // reference at the rising edge using the inputs that were held.
    task automatic cycle();
        bit hit;
        bit can_push;
        @(negedge clk);
        check("st_ready", st_ready, model_q.size() < DEPTH);
        check("empty", empty, model_q.size() == 0);
        check("mem_req", mem_req, model_q.size() > 0);
        if (model_q.size() > 0) begin
            check("mem_addr", mem_addr, model_q[0].addr);
            check("mem_wdata", mem_wdata, model_q[0].data);
            check("mem_be", mem_be, model_q[0].be);
        end else begin
            check("idle_addr", mem_addr, 0);
            check("idle_wdata", mem_wdata, 0);
            check("idle_be", mem_be, 0);
        end
        hit = 1'b0;
        foreach (model_q[i]) begin
            if (model_q[i].addr == ld_addr / 4) hit = 1'b1;
        end
        check("ld_conflict", ld_conflict, ld_check && hit);
        check("misalign", misalign, exp_mis);
        if (mem_req && mem_ack) pop_log.push_back(mem_addr);
        @(posedge clk);
        if (!reset_n) begin
            model_q.delete();
            exp_mis = 1'b0;
        end else begin
            can_push = model_q.size() < DEPTH;
            if (model_q.size() > 0 && mem_ack) void'(model_q.pop_front());
            exp_mis = st_valid && can_push && !ref_legal(st_size, st_addr);
            if (st_valid && can_push && ref_legal(st_size, st_addr))
                model_q.push_back(ref_entry(st_size, st_addr, st_data));
        end
        #1;
    endtask

    initial begin
        // Reset held with a store pending on the input: nothing may be queued.
        reset_n  = 1'b0;
        st_valid = 1'b1;
        st_size  = 2'b00;
        st_addr  = 32'h40;
        st_data  = 32'hDEADBEEF;
        mem_ack  = 1'b0;
        ld_check = 1'b0;
        ld_addr  = 32'h0;
        repeat (2) cycle();
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_empty", empty, 1);
        reset_n = 1'b1;
        cycle();
        st_valid = 1'b0;
        #2;
        check("first_req", mem_req, 1);
        check("first_addr", mem_addr, 30'h10);
        cycle();
        mem_ack = 1'b1;
        cycle();

        // SB to byte 3 of word 4.
        st_valid = 1'b1;
        st_size  = 2'b10;
        st_addr  = 32'h13;
        st_data  = 32'hAB;
        cycle();
        st_valid = 1'b0;
        #2;
        check("sb_addr", mem_addr, 30'h4);
        check("sb_wdata", mem_wdata, 32'hABABABAB);
        check("sb_be", mem_be, 4'b1000);
        cycle();
        #2;
        check("sb_drained", empty, 1);

        // SH to upper half, then a misaligned SH.
        mem_ack  = 1'b0;
        st_valid = 1'b1;
        st_size  = 2'b01;
        st_addr  = 32'h22;
        st_data  = 32'h1234;
        cycle();
        st_addr = 32'h21;
        cycle();
        st_valid = 1'b0;
        #2;
        check("sh_mis_pulse", misalign, 1);
        check("sh_be", mem_be, 4'b1100);
        check("sh_wdata", mem_wdata, 32'h12341234);
        cycle();
        #2;
        check("sh_mis_clear", misalign, 0);
        check("sh_one_entry", empty, 0);
        mem_ack = 1'b1;
        cycle();

        // Fill to DEPTH, hold a fifth store, then drain in order.
        mem_ack = 1'b0;
        pop_log.delete();
        st_size = 2'b00;
        for (int i = 0; i < 4; i++) begin
            st_valid = 1'b1;
            st_addr  = 32'(i * 4);
            st_data  = 32'hC0DE0000 + 32'(i);
            cycle();
        end
        st_addr = 32'h10;
        st_data = 32'hC0DE0004;
        #2;
        check("full_ready", st_ready, 0);
        cycle();
        cycle();
        mem_ack = 1'b1;
        cycle();
        mem_ack = 1'b0;
        #2;
        check("ready_after_pop", st_ready, 1);
        cycle();
        st_valid = 1'b0;
        mem_ack  = 1'b1;
        repeat (6) cycle();
        check("retire_count", pop_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < pop_log.size()) check("retire_order", pop_log[i], 30'(i));
        end

        // Load hazard against a pending SW to 0x100.
        mem_ack  = 1'b0;
        st_valid = 1'b1;
        st_addr  = 32'h100;
        cycle();
        st_valid = 1'b0;
        ld_check = 1'b1;
        ld_addr  = 32'h102;
        #2;
        check("ld_same_word", ld_conflict, 1);
        cycle();
        ld_addr = 32'h104;
        #2;
        check("ld_next_word", ld_conflict, 0);
        cycle();
        ld_check = 1'b0;
        ld_addr  = 32'h100;
        #2;
        check("ld_no_check", ld_conflict, 0);
        cycle();
        mem_ack = 1'b1;
        cycle();

        // Asynchronous reset mid-cycle with three stores queued.
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            st_valid = 1'b1;
            st_addr  = 32'h300 + 32'(i * 4);
            cycle();
        end
        st_valid = 1'b0;
        cycle();
        #1;
        reset_n = 1'b0;
        #1;
        check("async_mem_req", mem_req, 0);
        check("async_empty", empty, 1);
        check("async_ready", st_ready, 1);
        model_q.delete();
        exp_mis = 1'b0;
        mem_ack = 1'b1;
        cycle();
        cycle();
        reset_n = 1'b1;
        repeat (2) cycle();

        // Randomized traffic over a small address window to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            st_valid = 1'($urandom_range(0, 1));
            st_size  = 2'($urandom_range(0, 3));
            st_addr  = 32'h200 + 32'($urandom_range(0, 31));
            st_data  = $urandom;
            mem_ack  = ($urandom_range(0, 2) != 0);
            ld_check = 1'($urandom_range(0, 1));
            ld_addr  = 32'h200 + 32'($urandom_range(0, 31));
            cycle();
        end
        st_valid = 1'b0;
        mem_ack  = 1'b1;
        repeat (DEPTH + 1) cycle();
        check("final_empty", empty, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
